// File: rtl/aes_stream_adapter.sv
// ---------------------------------------------------------------------------
// aes_stream_adapter
//   Bridges a 32-bit valid/ready word stream and the block-level start/finish
//   interface of an AES128 core. Four input words are packed into a 128-bit
//   block (first word in the MSBs). The adapter then pulses aes_start and
//   waits for aes_finish under a watchdog. The result is serialised back out
//   as four words, MSB word first. Collect and drain never overlap.
//
// Ports
//   clk, arst            clock (rising edge), asynchronous active-high reset
//   key_load/key_data/   one-cycle key capture, honoured in COLLECT or DRAIN;
//   cipher_sel           a request in START/WAIT is dropped and flagged
//   s_valid/s_ready/     input word stream
//   s_data
//   m_valid/m_ready/     output word stream
//   m_data
//   aes_start/aes_din/   AES128 request side: start pulse, block, key and
//   aes_key_in/          direction (1 = encrypt)
//   aes_cipher
//   aes_dout/aes_finish  AES128 result side
//   busy                 high in START or WAIT
//   key_drop             sticky: key_load arrived while busy
//   timeout_err          sticky: no finish within TIMEOUT_CYCLES of WAIT
//   blk_cnt              count of fully drained blocks, wraps
// ---------------------------------------------------------------------------
module aes_stream_adapter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             key_load,
    input  logic [127:0]     key_data,
    input  logic             cipher_sel,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_data,
    output logic             aes_start,
    output logic [127:0]     aes_din,
    output logic [127:0]     aes_key_in,
    output logic             aes_cipher,
    input  logic [127:0]     aes_dout,
    input  logic             aes_finish,
    output logic             busy,
    output logic             key_drop,
    output logic             timeout_err,
    output logic [CNT_W-1:0] blk_cnt
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_START   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [1:0]        idx_r;
    logic [127:0]      din_r;
    logic [127:0]      key_r;
    logic              cipher_r;
    logic [127:0]      res_r;
    logic [WD_W-1:0]   wd_r;
    logic              key_drop_r;
    logic              timeout_r;
    logic [CNT_W-1:0]  blk_r;
    logic              aes_start_r;
    logic              m_valid_r;
    logic              busy_r;

    logic              accept_s;
    logic              xfer_s;
    logic              timeout_hit_s;
    logic              key_ok_s;

    // Selects 32-bit word idx of a block, word 0 being the MSBs.
    function automatic logic [31:0] word_sel(input logic [127:0] blk,
                                             input logic [1:0]   idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            2'd3:    w = blk[31:0];
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    assign accept_s      = s_valid && (state_r == ST_COLLECT);
    assign xfer_s        = m_ready && (state_r == ST_DRAIN);
    // Finish in the last watchdog cycle still wins over the abort.
    assign timeout_hit_s = (state_r == ST_WAIT) && !aes_finish && (wd_r == WD_LAST);
    assign key_ok_s      = (state_r == ST_COLLECT) || (state_r == ST_DRAIN);

    // Next-state logic for the collect/start/wait/drain sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_COLLECT: begin
                if (accept_s && (idx_r == 2'd3)) begin
                    state_s = ST_START;
                end else begin
                    state_s = ST_COLLECT;
                end
            end
            ST_START: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (aes_finish) begin
                    state_s = ST_DRAIN;
                end else if (timeout_hit_s) begin
                    state_s = ST_COLLECT;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (xfer_s && (idx_r == 2'd3)) begin
                    state_s = ST_COLLECT;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_COLLECT;
            end
        endcase
    end

    // State register plus the state-decoded outputs, registered from next state.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_r     <= ST_COLLECT;
            aes_start_r <= 1'b0;
            m_valid_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            aes_start_r <= (state_s == ST_START);
            m_valid_r   <= (state_s == ST_DRAIN);
            busy_r      <= (state_s == ST_START) || (state_s == ST_WAIT);
        end
    end

    // Word index shared by packing and serialising; wraps to 0 after word 3.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            idx_r <= 2'd0;
        end else if (timeout_hit_s) begin
            idx_r <= 2'd0;
        end else if (accept_s || xfer_s) begin
            idx_r <= idx_r + 2'd1;
        end else begin
            idx_r <= idx_r;
        end
    end

    // Input block packing, first accepted word into the MSBs.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            din_r <= 128'd0;
        end else if (accept_s) begin
            case (idx_r)
                2'd0:    din_r[127:96] <= s_data;
                2'd1:    din_r[95:64]  <= s_data;
                2'd2:    din_r[63:32]  <= s_data;
                2'd3:    din_r[31:0]   <= s_data;
                default: din_r         <= din_r;
            endcase
        end else begin
            din_r <= din_r;
        end
    end

    // Key and direction capture; requests while the core is busy are dropped.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            key_r      <= 128'd0;
            cipher_r   <= 1'b0;
            key_drop_r <= 1'b0;
        end else if (key_load && key_ok_s) begin
            key_r      <= key_data;
            cipher_r   <= cipher_sel;
            key_drop_r <= key_drop_r;
        end else if (key_load) begin
            key_r      <= key_r;
            cipher_r   <= cipher_r;
            key_drop_r <= 1'b1;
        end else begin
            key_r      <= key_r;
            cipher_r   <= cipher_r;
            key_drop_r <= key_drop_r;
        end
    end

    // Watchdog counts WAIT cycles; the abort itself is signalled by timeout_hit_s.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wd_r      <= {WD_W{1'b0}};
            timeout_r <= 1'b0;
        end else if (state_r == ST_START) begin
            wd_r      <= {WD_W{1'b0}};
            timeout_r <= timeout_r;
        end else if (timeout_hit_s) begin
            wd_r      <= {WD_W{1'b0}};
            timeout_r <= 1'b1;
        end else if (state_r == ST_WAIT) begin
            wd_r      <= wd_r + {{(WD_W-1){1'b0}}, 1'b1};
            timeout_r <= timeout_r;
        end else begin
            wd_r      <= wd_r;
            timeout_r <= timeout_r;
        end
    end

    // Result capture on finish (only honoured in WAIT) and drained-block count.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            res_r <= 128'd0;
            blk_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_WAIT) && aes_finish) begin
            res_r <= aes_dout;
            blk_r <= blk_r;
        end else if (xfer_s && (idx_r == 2'd3)) begin
            res_r <= res_r;
            blk_r <= blk_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            res_r <= res_r;
            blk_r <= blk_r;
        end
    end

    // s_ready is forced low for as long as reset is held.
    assign s_ready     = (state_r == ST_COLLECT) && !arst;
    assign m_valid     = m_valid_r;
    assign m_data      = word_sel(res_r, idx_r);
    assign aes_start   = aes_start_r;
    assign aes_din     = din_r;
    assign aes_key_in  = key_r;
    assign aes_cipher  = cipher_r;
    assign busy        = busy_r;
    assign key_drop    = key_drop_r;
    assign timeout_err = timeout_r;
    assign blk_cnt     = blk_r;

endmodule

// File: tb/tb_aes_stream_adapter.sv
// ---------------------------------------------------------------------------
// Bench for aes_stream_adapter. The bench plays the AES128 core itself: the
// stub answers the FIPS-197 vector exactly and any other block with a keyed
// scramble, so every expected output word comes from the bench's own model.
// Inputs are driven on the falling edge and outputs are checked there too.
// ---------------------------------------------------------------------------
module tb_aes_stream_adapter;

    localparam int TO = 8;

    localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         arst = 1'b0;
    logic         key_load = 1'b0;
    logic [127:0] key_data = 128'd0;
    logic         cipher_sel = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [31:0]  s_data = 32'd0;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [31:0]  m_data;
    logic         aes_start;
    logic [127:0] aes_din;
    logic [127:0] aes_key_in;
    logic         aes_cipher;
    logic [127:0] aes_dout = 128'd0;
    logic         aes_finish = 1'b0;
    logic         busy;
    logic         key_drop;
    logic         timeout_err;
    logic [15:0]  blk_cnt;

    int n_run = 0;
    int n_fail = 0;
    int start_cnt = 0;
    int exp_starts = 0;

    // Reference state derived from the stimulus.
    logic [127:0] m_key = 128'd0;
    logic         m_cipher = 1'b0;
    logic         m_kdrop = 1'b0;
    logic         m_tout = 1'b0;
    int           m_blk = 0;

    aes_stream_adapter #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .clk(clk), .arst(arst), .key_load(key_load), .key_data(key_data),
        .cipher_sel(cipher_sel), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .aes_start(aes_start), .aes_din(aes_din), .aes_key_in(aes_key_in),
        .aes_cipher(aes_cipher), .aes_dout(aes_dout), .aes_finish(aes_finish),
        .busy(busy), .key_drop(key_drop), .timeout_err(timeout_err),
        .blk_cnt(blk_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (aes_start) start_cnt <= start_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1);
    end

    function automatic logic [127:0] mock_aes(input logic [127:0] k,
                                              input logic [127:0] d,
                                              input logic e);
        if (k == FK && e && d == FP) return FC;
        if (k == FK && !e && d == FC) return FP;
        return d ^ {k[63:0], k[127:64]} ^ (e ? {4{32'ha5c3_0f96}} : {4{32'h5a3c_f069}});
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a falling edge in COLLECT.
    task automatic load_key(input logic [127:0] k, input logic c);
        key_load = 1'b1; key_data = k; cipher_sel = c;
        @(negedge clk);
        key_load = 1'b0; key_data = rand128();
        m_key = k; m_cipher = c;
        chk("key_loaded", aes_key_in, m_key);
        chk("cipher_loaded", aes_cipher, m_cipher);
    endtask

    task automatic send_word(input logic [31:0] w);
        int g;
        int guard;
        g = $urandom_range(0, 2);
        repeat (g) @(negedge clk);
        s_valid = 1'b1; s_data = w; guard = 0;
        while (!s_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("s_ready_bound", 128'd0, 128'd1);
        @(negedge clk);
        s_valid = 1'b0; s_data = $urandom;
    endtask

    task automatic drain(input logic [127:0] res, input bit hold5);
        for (int k = 0; k < 4; k++) begin
            int st;
            logic [31:0] w;
            w = res[127-32*k -: 32];
            st = hold5 ? 5 : $urandom_range(0, 3);
            m_ready = 1'b0;
            for (int j = 0; j < st; j++) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, w);
                chk("hold_s_ready", s_ready, 0);
                @(negedge clk);
            end
            chk("drain_valid", m_valid, 1);
            chk("drain_data", m_data, w);
            m_ready = 1'b1;
            @(negedge clk);
        end
        m_ready = 1'b0;
        m_blk++;
        chk("after_drain_m_valid", m_valid, 0);
        chk("after_drain_s_ready", s_ready, 1);
        chk("blk_cnt", blk_cnt, 16'(m_blk));
    endtask

    // fin_d > 0: finish in WAIT cycle fin_d; fin_d <= 0: finish withheld.
    task automatic run_block(input logic [127:0] blk, input int fin_d,
                             input bit hold5, input bit kdrop, input bit midkey);
        logic [127:0] res;
        int c;
        bit done;
        for (int i = 0; i < 4; i++) begin
            send_word(blk[127-32*i -: 32]);
            if (midkey && i == 1) load_key(rand128(), 1'($urandom_range(0, 1)));
        end
        exp_starts++;
        chk("start_pulse", aes_start, 1);
        chk("start_busy", busy, 1);
        chk("start_s_ready", s_ready, 0);
        chk("aes_din", aes_din, blk);
        chk("aes_key_in", aes_key_in, m_key);
        chk("aes_cipher", aes_cipher, m_cipher);
        res = mock_aes(m_key, blk, m_cipher);
        c = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            c++;
            aes_dout = rand128();
            if (c == 1) chk("start_one_cycle", aes_start, 0);
            if (kdrop && c == 2) begin
                key_load = 1'b1; key_data = ~m_key; cipher_sel = ~m_cipher;
            end
            if (kdrop && c == 3) begin
                key_load = 1'b0;
                m_kdrop = 1'b1;
                chk("key_drop_set", key_drop, 1);
                chk("key_unchanged", aes_key_in, m_key);
                chk("cipher_unchanged", aes_cipher, m_cipher);
            end
            if (fin_d > 0 && c == fin_d) begin
                aes_finish = 1'b1; aes_dout = res;
                @(negedge clk);
                aes_finish = 1'b0; aes_dout = rand128();
                done = 1;
                chk("finish_to_m_valid", m_valid, 1);
                chk("drain_not_busy", busy, 0);
            end else if (fin_d <= 0 && c == TO) begin
                chk("wd_last_cycle_flag", timeout_err, m_tout);
                @(negedge clk);
                m_tout = 1'b1;
                done = 1;
                chk("timeout_err", timeout_err, 1);
                chk("timeout_no_m_valid", m_valid, 0);
                chk("timeout_s_ready", s_ready, 1);
                chk("timeout_not_busy", busy, 0);
            end else begin
                chk("wait_busy", busy, 1);
                chk("wait_no_m_valid", m_valid, 0);
            end
        end
        if (fin_d > 0) drain(res, hold5);
        chk("start_count", start_cnt, exp_starts);
        chk("key_drop_sticky", key_drop, m_kdrop);
        chk("timeout_sticky", timeout_err, m_tout);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_aes_start"}, aes_start, 0);
        chk({tag, "_aes_din"}, aes_din, 0);
        chk({tag, "_aes_key_in"}, aes_key_in, 0);
        chk({tag, "_aes_cipher"}, aes_cipher, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_key_drop"}, key_drop, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
        chk({tag, "_blk_cnt"}, blk_cnt, 0);
    endtask

    initial begin
        // Reset state.
        #1 arst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        arst = 1'b0;
        #1 chk("release_s_ready", s_ready, 1);
        @(negedge clk);

        // Finish outside WAIT is ignored.
        aes_finish = 1'b1; aes_dout = rand128();
        @(negedge clk);
        aes_finish = 1'b0;
        @(negedge clk);
        chk("stray_finish_m_valid", m_valid, 0);
        chk("stray_finish_s_ready", s_ready, 1);

        // FIPS-197 encrypt and decrypt.
        load_key(FK, 1'b1);
        run_block(FP, 3, 0, 0, 0);
        load_key(FK, 1'b0);
        run_block(FC, 2, 0, 0, 0);

        // Backpressure of 5 cycles on every output word.
        run_block(rand128(), 4, 1, 0, 0);

        // Key load while busy is dropped; block still encrypts with the old key.
        load_key(FK, 1'b1);
        run_block(FP, 6, 0, 1, 0);

        // Withheld finish, then a normal block.
        run_block(rand128(), 0, 0, 0, 0);
        run_block(rand128(), 1, 0, 0, 0);

        // Finish in the last watchdog cycle beats the abort.
        run_block(rand128(), TO, 0, 0, 0);

        // Reset while in WAIT.
        for (int i = 0; i < 4; i++) send_word($urandom);
        exp_starts++;
        repeat (2) @(negedge clk);
        #2 arst = 1'b1;
        #1 check_reset_outputs("wait_reset");
        m_key = 128'd0; m_cipher = 1'b0; m_kdrop = 1'b0; m_tout = 1'b0; m_blk = 0;
        @(negedge clk);
        arst = 1'b0;
        #1 chk("post_reset_s_ready", s_ready, 1);
        @(negedge clk);
        chk("post_reset_no_m_valid", m_valid, 0);
        chk("post_reset_blk_cnt", blk_cnt, 0);

        // Randomized blocks, some with a key loaded mid-collection.
        load_key(rand128(), 1'b1);
        for (int b = 0; b < 6; b++) begin
            run_block(rand128(), $urandom_range(1, TO), 0, 0, bit'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
